i2c_slave_rsp: RTL and testbench

I2C_SLAVE_RSP -- requirements
Module: i2c_slave_rsp

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_bus_cond_det.sv | 48 ++++
 rtl/i2c_slave_rsp.sv | 188 ++++++++++++++++++
 tb/tb_i2c_slave_rsp.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C slave-responder definitions: bus widths, default address and the
// FSM state encoding used by i2c_slave_rsp.
package i2c_pkg;

  localparam int I2C_ADDR_WIDTH = 7;
  localparam int I2C_DATA_WIDTH = 8;
  localparam logic [I2C_ADDR_WIDTH-1:0] I2C_SLAVE_ADDRESS = 7'h22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_rsp_state_t;

endpackage

// File: rtl/i2c_bus_cond_det.sv
// Brings SCL/SDA into the clk_i domain and flags SCL edges plus START/STOP
// conditions as single-cycle pulses on the synchronized values.
module i2c_bus_cond_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_prev;
  logic       sda_prev;
  logic       scl_s;

  // Two-flop synchronizers plus one history flop per line for edge detection;
  // the idle bus is high, so everything resets to 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // which is what makes this a shift chain rather than a single wire.
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

  // SCL must be stably high on both samples for an SDA edge to count as START/STOP.
  assign scl_rise  =  scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s &  scl_prev;
  assign start_det =  scl_s &  scl_prev &  sda_prev & ~sda_s;
  assign stop_det  =  scl_s &  scl_prev & ~sda_prev &  sda_s;

endmodule

// File: rtl/i2c_slave_rsp.sv
// I2C slave with a small register file: the first write byte sets the pointer,
// later write bytes store at the pointer, reads stream from the pointer. The
// pointer auto-increments and wraps at MEM_DEPTH in both directions.
module i2c_slave_rsp #(
  parameter int I2C_ADDR_WIDTH = i2c_pkg::I2C_ADDR_WIDTH,
  parameter int I2C_DATA_WIDTH = i2c_pkg::I2C_DATA_WIDTH,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDRESS = i2c_pkg::I2C_SLAVE_ADDRESS,
  parameter int MEM_DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_o,
  output logic                         busy,
  output logic                         rx_valid,
  output logic [$clog2(MEM_DEPTH)-1:0] rx_ptr,
  output logic [I2C_DATA_WIDTH-1:0]    rx_data
);

  import i2c_pkg::*;

  localparam int PTR_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(I2C_DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(I2C_DATA_WIDTH);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_rsp_state_t              state_q, state_nxt;
  logic [CNT_W-1:0]            bit_cnt_q;
  logic [I2C_DATA_WIDTH-1:0]   shift_q;
  logic [PTR_W-1:0]            ptr_q;
  logic                        wr_first_q;
  logic                        ack_q;
  logic [I2C_DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  logic byte_done;
  logic addr_match;
  logic rw_bit;

  i2c_bus_cond_det u_det (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign byte_done  = (bit_cnt_q == CNT_FULL);
  assign addr_match = (shift_q[I2C_DATA_WIDTH-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDRESS);
  assign rw_bit     = shift_q[0];

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  // Next-state logic: START/STOP win over everything, otherwise advance on SCL falls.
  always_comb begin
    // NOTE: assigning a default before any branch keeps this block free of latches.
    state_nxt = state_q;
    if (start_det) begin
      state_nxt = ST_ADDR;
    end else if (stop_det) begin
      state_nxt = ST_IDLE;
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR:     if (byte_done) state_nxt = addr_match ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK: state_nxt = rw_bit ? ST_RD_BYTE : ST_WR_BYTE;
        ST_WR_BYTE:  if (byte_done) state_nxt = ST_WR_ACK;
        ST_WR_ACK:   state_nxt = ST_WR_BYTE;
        ST_RD_BYTE:  if (byte_done) state_nxt = ST_RD_ACK;
        ST_RD_ACK:   state_nxt = ack_q ? ST_IGNORE : ST_RD_BYTE;
        default:     state_nxt = state_q;
      endcase
    end
  end

  // Busy covers the addressed part of a transaction, from address ACK onward.
  always_comb begin
    busy = 1'b0;
    case (state_q)
      ST_ADDR_ACK, ST_WR_BYTE, ST_WR_ACK, ST_RD_BYTE, ST_RD_ACK: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Datapath: bit shifting, pointer, register file and the SDA drive. SDA only
  // moves on a detected SCL fall (or releases on START/STOP/reset), so the
  // line is always stable while SCL is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sda_o      <= 1'b1;
      rx_valid   <= 1'b0;
      rx_ptr     <= '0;
      rx_data    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      wr_first_q <= 1'b0;
      ack_q      <= 1'b1;
      // NOTE: the register file is cleared by reset so reads after reset are
      // defined; this costs a reset net on every entry.
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (start_det || stop_det) begin
        // A partial byte is simply dropped: nothing is committed until a byte completes.
        bit_cnt_q <= '0;
        sda_o     <= 1'b1;
      end else begin
        if (scl_rise) begin
          case (state_q)
            ST_ADDR, ST_WR_BYTE: begin
              shift_q   <= {shift_q[I2C_DATA_WIDTH-2:0], sda_s};
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
            ST_RD_BYTE: bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            ST_RD_ACK:  ack_q     <= sda_s;
            default: ;
          endcase
        end
        if (scl_fall) begin
          case (state_q)
            ST_ADDR: begin
              if (byte_done) begin
                bit_cnt_q <= '0;
                sda_o     <= ~addr_match;
              end
            end
            ST_ADDR_ACK: begin
              bit_cnt_q <= '0;
              if (rw_bit) begin
                shift_q <= mem_q[ptr_q];
                sda_o   <= mem_q[ptr_q][I2C_DATA_WIDTH-1];
              end else begin
                sda_o      <= 1'b1;
                wr_first_q <= 1'b1;
              end
            end
            ST_WR_BYTE: begin
              if (byte_done) begin
                bit_cnt_q <= '0;
                sda_o     <= 1'b0;
                if (wr_first_q) begin
                  ptr_q      <= shift_q[PTR_W-1:0];
                  wr_first_q <= 1'b0;
                end else begin
                  mem_q[ptr_q] <= shift_q;
                  rx_valid     <= 1'b1;
                  rx_ptr       <= ptr_q;
                  rx_data      <= shift_q;
                  ptr_q        <= ptr_q + PTR_W'(1);
                end
              end
            end
            ST_WR_ACK: sda_o <= 1'b1;
            ST_RD_BYTE: begin
              if (byte_done) begin
                bit_cnt_q <= '0;
                sda_o     <= 1'b1;
                ptr_q     <= ptr_q + PTR_W'(1);
              end else begin
                shift_q <= {shift_q[I2C_DATA_WIDTH-2:0], 1'b0};
                sda_o   <= shift_q[I2C_DATA_WIDTH-2];
              end
            end
            ST_RD_ACK: begin
              if (!ack_q) begin
                shift_q <= mem_q[ptr_q];
                sda_o   <= mem_q[ptr_q][I2C_DATA_WIDTH-1];
              end else begin
                sda_o <= 1'b1;
              end
            end
            default: sda_o <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_rsp.sv
// Self-checking bench for i2c_slave_rsp: a bit-banged I2C master drives a
// table of bus steps, then hand-written sequences cover aborted bytes, a
// non-matching address and reset during a read.
module tb_i2c_slave_rsp;

  localparam int HALF = 8;   // clk cycles per SCL phase

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_sda;
  logic       sda_line;
  logic       sda_o;
  logic       busy;
  logic       rx_valid;
  logic [3:0] rx_ptr;
  logic [7:0] rx_data;

  int checks   = 0;
  int failures = 0;

  assign sda_line = m_sda & sda_o;

  always #5 clk = ~clk;

  i2c_slave_rsp #(.SLAVE_ADDRESS(7'h22), .MEM_DEPTH(16)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .scl_i    (scl),
    .sda_i    (sda_line),
    .sda_o    (sda_o),
    .busy     (busy),
    .rx_valid (rx_valid),
    .rx_ptr   (rx_ptr),
    .rx_data  (rx_data)
  );

  typedef enum {OP_START, OP_STOP, OP_WR, OP_RD} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] data;      // write data, or expected read data
    logic       flag;      // OP_WR: expected ACK bit; OP_RD: master NACK
    logic       exp_busy;  // busy once the step has settled
  } step_t;

  // Captured write strobes {ptr, data}.
  logic [11:0] rx_log [$];
  logic        sda_o_prev = 1'b1;
  int          hi_drive_viol = 0;
  bit          win_on = 1'b0;
  int          win_low = 0;
  int          win_busy = 0;

  // Monitors: rx strobes, slave pulling SDA low while SCL high, and a window
  // counter for the ignored-address transaction.
  always @(negedge clk) begin
    if (rx_valid) rx_log.push_back({rx_ptr, rx_data});
    if (!rst && scl && sda_o_prev && !sda_o) hi_drive_viol <= hi_drive_viol + 1;
    sda_o_prev <= sda_o;
    if (win_on && !sda_o) win_low  <= win_low + 1;
    if (win_on && busy)   win_busy <= win_busy + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; bus_wait(HALF);
    scl   = 1'b1; bus_wait(HALF);
    m_sda = 1'b0; bus_wait(HALF);
    scl   = 1'b0; bus_wait(2);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; bus_wait(HALF);
    scl   = 1'b1; bus_wait(HALF);
    m_sda = 1'b1; bus_wait(HALF);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    bus_wait(HALF);
    scl   = 1'b1; bus_wait(HALF);
    scl   = 1'b0; bus_wait(2);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; bus_wait(HALF);
    scl   = 1'b1; bus_wait(HALF / 2);
    b     = sda_line;
    bus_wait(HALF / 2);
    scl   = 1'b0; bus_wait(2);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  function automatic step_t mk(op_e op, logic [7:0] d, logic f, logic b);
    step_t s;
    s.op = op; s.data = d; s.flag = f; s.exp_busy = b;
    return s;
  endfunction

  initial begin
    step_t       steps [$];
    logic        ack;
    logic        bit_v;
    logic [7:0]  rd;
    logic [6:0]  rd7;
    logic [11:0] exp_rx [4];

    // Write ptr 3 + two data bytes; write-then-read via repeated START;
    // pointer wrap at 15 -> 0 on write and on read.
    steps.push_back(mk(OP_START, 8'h00, 1'b0, 1'b0));
    steps.push_back(mk(OP_WR,    8'h44, 1'b0, 1'b1));
    steps.push_back(mk(OP_WR,    8'h03, 1'b0, 1'b1));
    steps.push_back(mk(OP_WR,    8'hA5, 1'b0, 1'b1));
    steps.push_back(mk(OP_WR,    8'h5A, 1'b0, 1'b1));
    steps.push_back(mk(OP_STOP,  8'h00, 1'b0, 1'b0));
    steps.push_back(mk(OP_START, 8'h00, 1'b0, 1'b0));
    steps.push_back(mk(OP_WR,    8'h44, 1'b0, 1'b1));
    steps.push_back(mk(OP_WR,    8'h03, 1'b0, 1'b1));
    steps.push_back(mk(OP_START, 8'h00, 1'b0, 1'b0));
    steps.push_back(mk(OP_WR,    8'h45, 1'b0, 1'b1));
    steps.push_back(mk(OP_RD,    8'hA5, 1'b0, 1'b1));
    steps.push_back(mk(OP_RD,    8'h5A, 1'b1, 1'b0));
    steps.push_back(mk(OP_STOP,  8'h00, 1'b0, 1'b0));
    steps.push_back(mk(OP_START, 8'h00, 1'b0, 1'b0));
    steps.push_back(mk(OP_WR,    8'h44, 1'b0, 1'b1));
    steps.push_back(mk(OP_WR,    8'h0F, 1'b0, 1'b1));
    steps.push_back(mk(OP_WR,    8'h11, 1'b0, 1'b1));
    steps.push_back(mk(OP_WR,    8'h22, 1'b0, 1'b1));
    steps.push_back(mk(OP_STOP,  8'h00, 1'b0, 1'b0));
    steps.push_back(mk(OP_START, 8'h00, 1'b0, 1'b0));
    steps.push_back(mk(OP_WR,    8'h44, 1'b0, 1'b1));
    steps.push_back(mk(OP_WR,    8'h0F, 1'b0, 1'b1));
    steps.push_back(mk(OP_START, 8'h00, 1'b0, 1'b0));
    steps.push_back(mk(OP_WR,    8'h45, 1'b0, 1'b1));
    steps.push_back(mk(OP_RD,    8'h11, 1'b0, 1'b1));
    steps.push_back(mk(OP_RD,    8'h22, 1'b1, 1'b0));
    steps.push_back(mk(OP_STOP,  8'h00, 1'b0, 1'b0));

    exp_rx[0] = {4'd3,  8'hA5};
    exp_rx[1] = {4'd4,  8'h5A};
    exp_rx[2] = {4'd15, 8'h11};
    exp_rx[3] = {4'd0,  8'h22};

    // Reset state.
    rst = 1'b1; scl = 1'b1; m_sda = 1'b1;
    bus_wait(5);
    check("rst_sda_o",    sda_o,    1);
    check("rst_busy",     busy,     0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_ptr",   rx_ptr,   0);
    check("rst_rx_data",  rx_data,  0);
    rst = 1'b0;
    bus_wait(4);

    // Table-driven transactions.
    foreach (steps[i]) begin
      case (steps[i].op)
        OP_START: i2c_start();
        OP_STOP:  i2c_stop();
        OP_WR: begin
          write_byte(steps[i].data, ack);
          check($sformatf("step%0d_ack", i), ack, steps[i].flag);
        end
        default: begin
          read_byte(steps[i].flag, rd);
          check($sformatf("step%0d_rd", i), rd, steps[i].data);
        end
      endcase
      bus_wait(6);
      check($sformatf("step%0d_busy", i), busy, steps[i].exp_busy);
    end

    check("rx_count", rx_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rx_log.size()) check($sformatf("rx%0d", i), rx_log[i], exp_rx[i]);
      else                   check($sformatf("rx%0d_missing", i), 0, exp_rx[i]);
    end

    // Address 0x23: no ACK, SDA never pulled, busy never raised.
    win_on = 1'b1;
    i2c_start();
    write_byte(8'h46, ack);
    check("nomatch_addr_ack", ack, 1);
    write_byte(8'h12, ack);
    check("nomatch_data_ack", ack, 1);
    i2c_stop();
    bus_wait(2);
    win_on = 1'b0;
    check("nomatch_sda_low_cycles", win_low, 0);
    check("nomatch_busy_cycles",    win_busy, 0);

    // STOP after 4 bits of a data byte: discarded, pointer stays at 4.
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h04, ack);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    check("abort_rx_count", rx_log.size(), 4);
    i2c_start();
    write_byte(8'h45, ack);
    read_byte(1'b1, rd);
    check("abort_readback", rd, 8'h5A);
    i2c_stop();

    // Reset while the slave drives bit 0 (a 0) of mem[0]=0x22.
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h00, ack);
    i2c_start();
    write_byte(8'h45, ack);
    check("rstrd_addr_ack", ack, 0);
    rd7 = '0;
    for (int i = 0; i < 7; i++) begin
      read_bit(bit_v);
      rd7 = {rd7[5:0], bit_v};
    end
    check("rstrd_7bits", rd7, 7'h11);
    bus_wait(6);
    check("rstrd_pre_sda_o", sda_o, 0);
    check("rstrd_pre_busy",  busy,  1);
    rst = 1'b1;
    bus_wait(1);
    check("rstrd_post_sda_o", sda_o, 1);
    check("rstrd_post_busy",  busy,  0);
    rst = 1'b0;
    scl = 1'b1; bus_wait(HALF);
    scl = 1'b0; bus_wait(2);
    write_byte(8'h44, ack);
    check("rstrd_ignored_ack", ack, 1);
    i2c_stop();
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h00, ack);
    i2c_start();
    write_byte(8'h45, ack);
    read_byte(1'b1, rd);
    check("rstrd_mem0_cleared", rd, 8'h00);
    i2c_stop();

    check("rx_count_final", rx_log.size(), 4);
    check("sda_fell_while_scl_high", hi_drive_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
